// File: rtl/sequence_controller.sv
// Instruction sequencer for the 8-bit accumulator CPU.
// Steps the 8-phase fetch/execute cycle and decodes control strobes.
module sequence_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  phase_e state_q;
  phase_e state_d;
  logic   halted_q;
  logic   halted_d;
  logic   aluop;

  assign aluop = (opcode == ADD) || (opcode == AND) ||
                 (opcode == XOR) || (opcode == LDA);
  assign phase = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;
    // Halted: phase freezes (at OP_FETCH) and only halt is driven.
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      state_d = phase_e'(state_q + 3'd1);
      if (state_q == OP_ADDR && opcode == HLT)
        halted_d = 1'b1;
      unique case (state_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != HLT);
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_pc  = (opcode == JMP);
          ld_ac  = aluop;
          data_e = (opcode == STO);
          wr     = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule
